// File: rtl/i2c_burst_xfer.sv
// i2c_burst_xfer: drives a byte-level i2c_master through a register
//   address phase (1 or 2 bytes, MSB first) and a burst of 1..MAX_BURST data
//   bytes. It retries the whole command list on NACK and aborts on a per-attempt
//   watchdog.
// Latency: busy/m_ena rise 1 cycle after start. The next command is registered
//   1 cycle after each m_busy rise. rd_valid fires 1 cycle after m_busy falls.
//   done fires 2 cycles after the final m_busy fall.
// Backpressure: the master paces the transfer through m_busy. start is ignored
//   while busy.
// Ports:
//   clk, reset (sync, active-low)
//   start, chip_addr, reg_addr, is_read, len, wr_data : transfer request, all sampled at start
//   rd_data, rd_valid, rd_idx : read byte stream
//   busy, done, error : status (error 0 ok, 1 NACK after retries, 2 timeout)
//   m_ena, m_addr, m_rw, m_data_wr / m_busy, m_data_rd, m_ack_error : i2c_master command/status
module i2c_burst_xfer #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_BURST      = 8,
  parameter int RETRIES        = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int LEN_W          = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             chip_addr,
  input  logic [15:0]            reg_addr,
  input  logic                   is_read,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BURST-1:0] wr_data,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [LEN_W-1:0]       rd_idx,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             error,
  output logic                   m_ena,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_data_wr,
  input  logic                   m_busy,
  input  logic [7:0]             m_data_rd,
  input  logic                   m_ack_error
);

  localparam int CNT_W = $clog2(REG_ADDR_BYTES + MAX_BURST + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AT_W  = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [CNT_W-1:0] A_C = CNT_W'(REG_ADDR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DRAIN, S_CHECK, S_GAP, S_FIN
  } state_t;

  state_t                 state, state_nxt;
  logic                   m_busy_q;
  logic                   busy_rise, busy_fall;
  logic [15:0]            reg_q;
  logic                   rd_q;
  logic [CNT_W-1:0]       n_q;
  logic [8*MAX_BURST-1:0] wdat_q;
  logic [CNT_W-1:0]       k, k_inc, total;
  logic [AT_W-1:0]        attempt;
  logic [WD_W-1:0]        wdog;
  logic                   wd_expire;
  logic [3:0]             gap_cnt;
  logic                   inflight_rw;
  logic [LEN_W-1:0]       rd_cnt;
  logic [LEN_W-1:0]       len_c;

  assign busy_rise = m_busy & ~m_busy_q;
  assign busy_fall = ~m_busy & m_busy_q;
  assign k_inc     = k + CNT_W'(1);
  assign total     = A_C + n_q;
  assign wd_expire = (wdog == WD_W'(TIMEOUT_CYCLES));

  // Byte count clamped into 1..MAX_BURST
  always_comb begin
    len_c = len;
    if (len == '0)
      len_c = LEN_W'(1);
    else if (len > LEN_W'(MAX_BURST))
      len_c = LEN_W'(MAX_BURST);
  end

  // Command idx of the list: {rw, byte}. Address bytes first (rw=0), then data.
  function automatic logic [8:0] cmd_at(input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] didx;
    logic             hi_sel;
    cmd_at = 9'h000;
    didx   = idx - A_C;
    hi_sel = (REG_ADDR_BYTES == 2) && (idx == '0);
    if (idx < A_C) begin
      cmd_at = {1'b0, hi_sel ? reg_q[15:8] : reg_q[7:0]};
    end else begin
      cmd_at[8] = rd_q;
      for (int i = 0; i < MAX_BURST; i++)
        if (didx == CNT_W'(i)) cmd_at[7:0] = wdat_q[8*i +: 8];
    end
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CMD;
      S_CMD: begin
        if (wd_expire)
          state_nxt = S_FIN;
        else if (busy_rise && (k_inc == total))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wd_expire)
          state_nxt = S_FIN;
        else if (busy_fall)
          state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (m_ack_error && (attempt < AT_W'(RETRIES)))
          state_nxt = S_GAP;
        else
          state_nxt = S_FIN;
      end
      S_GAP:   if (gap_cnt == 4'd15) state_nxt = S_CMD;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      m_busy_q    <= 1'b0;
      m_ena       <= 1'b0;
      m_addr      <= 7'h00;
      m_rw        <= 1'b0;
      m_data_wr   <= 8'h00;
      rd_data     <= 8'h00;
      rd_valid    <= 1'b0;
      rd_idx      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 2'd0;
      reg_q       <= 16'h0000;
      rd_q        <= 1'b0;
      n_q         <= '0;
      wdat_q      <= '0;
      k           <= '0;
      attempt     <= '0;
      wdog        <= '0;
      gap_cnt     <= 4'd0;
      inflight_rw <= 1'b0;
      rd_cnt      <= '0;
    end else begin
      state    <= state_nxt;
      m_busy_q <= m_busy;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            reg_q       <= reg_addr;
            rd_q        <= is_read;
            n_q         <= CNT_W'(len_c);
            wdat_q      <= wr_data;
            busy        <= 1'b1;
            error       <= 2'd0;
            attempt     <= '0;
            k           <= '0;
            wdog        <= '0;
            rd_cnt      <= '0;
            inflight_rw <= 1'b0;
            m_ena       <= 1'b1;
            m_addr      <= chip_addr;
            m_rw        <= 1'b0;
            m_data_wr   <= (REG_ADDR_BYTES == 2) ? reg_addr[15:8] : reg_addr[7:0];
          end
        end
        S_CMD, S_DRAIN: begin
          wdog <= wdog + WD_W'(1);
          if ((state == S_CMD) && busy_rise) begin
            // The command just accepted is what m_rw shows now.
            inflight_rw <= m_rw;
            k           <= k_inc;
            if (k_inc == total)
              m_ena <= 1'b0;
            else
              {m_rw, m_data_wr} <= cmd_at(k_inc);
          end
          if (busy_fall && inflight_rw) begin
            rd_data  <= m_data_rd;
            rd_valid <= 1'b1;
            rd_idx   <= rd_cnt;
            rd_cnt   <= rd_cnt + LEN_W'(1);
          end
          if (wd_expire) begin
            m_ena <= 1'b0;
            error <= 2'd2;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (state_nxt == S_GAP) begin
            attempt <= attempt + AT_W'(1);
            gap_cnt <= 4'd0;
          end else begin
            error <= m_ack_error ? 2'd1 : 2'd0;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (state_nxt == S_CMD) begin
            // Retry: reissue the full list and restart read numbering.
            k                 <= '0;
            wdog              <= '0;
            rd_cnt            <= '0;
            inflight_rw       <= 1'b0;
            m_ena             <= 1'b1;
            {m_rw, m_data_wr} <= cmd_at('0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_burst_xfer.sv
module tb_i2c_burst_xfer;

  localparam int BYTE_T = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  chip_addr = 7'h00;
  logic [15:0] reg_addr = 16'h0000;
  logic        is_read = 1'b0;
  logic [3:0]  len = 4'd0;
  logic [63:0] wr_data = 64'h0;
  bit          sel = 1'b0;
  bit          hold = 1'b0;
  bit          mb;
  logic        s_ack_err;
  logic [7:0]  s_rd;

  logic [7:0] rd_data1, rd_data2, m_data_wr1, m_data_wr2;
  logic [3:0] rd_idx1, rd_idx2;
  logic [6:0] m_addr1, m_addr2;
  logic [1:0] error1, error2;
  logic rd_valid1, rd_valid2, busy1, busy2, done1, done2, m_ena1, m_ena2, m_rw1, m_rw2;

  always #5 clk = ~clk;

  wire start1 = start & ~sel;
  wire start2 = start & sel;
  wire mbusy1 = sel ? 1'b0 : (mb | hold);
  wire mbusy2 = sel ? (mb | hold) : 1'b0;

  i2c_burst_xfer #(.REG_ADDR_BYTES(1), .MAX_BURST(8), .RETRIES(2), .TIMEOUT_CYCLES(1000)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .chip_addr(chip_addr), .reg_addr(reg_addr),
    .is_read(is_read), .len(len), .wr_data(wr_data), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rd_idx(rd_idx1), .busy(busy1), .done(done1), .error(error1), .m_ena(m_ena1),
    .m_addr(m_addr1), .m_rw(m_rw1), .m_data_wr(m_data_wr1), .m_busy(mbusy1),
    .m_data_rd(s_rd), .m_ack_error(s_ack_err));

  i2c_burst_xfer #(.REG_ADDR_BYTES(2), .MAX_BURST(8), .RETRIES(2), .TIMEOUT_CYCLES(1000)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .chip_addr(chip_addr), .reg_addr(reg_addr),
    .is_read(is_read), .len(len), .wr_data(wr_data), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .rd_idx(rd_idx2), .busy(busy2), .done(done2), .error(error2), .m_ena(m_ena2),
    .m_addr(m_addr2), .m_rw(m_rw2), .m_data_wr(m_data_wr2), .m_busy(mbusy2),
    .m_data_rd(s_rd), .m_ack_error(s_ack_err));

  wire [7:0] rd_data_s   = sel ? rd_data2 : rd_data1;
  wire [3:0] rd_idx_s    = sel ? rd_idx2 : rd_idx1;
  wire       rd_valid_s  = sel ? rd_valid2 : rd_valid1;
  wire       busy_s      = sel ? busy2 : busy1;
  wire       done_s      = sel ? done2 : done1;
  wire [1:0] error_s     = sel ? error2 : error1;
  wire       m_ena_s     = sel ? m_ena2 : m_ena1;
  wire [6:0] m_addr_s    = sel ? m_addr2 : m_addr1;
  wire       m_rw_s      = sel ? m_rw2 : m_rw1;
  wire [7:0] m_data_wr_s = sel ? m_data_wr2 : m_data_wr1;
  wire [33:0] outs_s = {m_ena_s, m_addr_s, m_rw_s, m_data_wr_s, rd_data_s, rd_valid_s,
                        rd_idx_s, busy_s, done_s, error_s};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt, done_cyc, ts;
  logic [1:0] done_err;
  logic done_ena;
  logic [7:0] sd[$];
  int si[$];
  int buslog[$];
  int expq[$];
  int att_cnt, nack_n, rp;
  bit mdl_idle, first, more, prev_rw, cur_rw, nack_now;

  typedef struct {
    bit          a2;
    bit          rd;
    logic [6:0]  chip;
    logic [15:0] regad;
    logic [3:0]  len;
    logic [63:0] wr;
    int          nack;
    int          exp_n;
    int          exp_att;
    logic [1:0]  exp_err;
    int          exp_rd;
  } vec_t;
  vec_t vt[9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_s) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error_s;
      done_ena = m_ena_s;
    end
    if (rd_valid_s) begin
      sd.push_back(rd_data_s);
      si.push_back(int'(rd_idx_s));
    end
  end

  // Behavioural i2c_master plus slave. Logs bus activity as:
  // 0x100|addr_byte = (repeated) start + address, 0..0xFF = written byte,
  // 0x200 = read byte, 0x300 = stop.
  initial begin : master_model
    mb = 1'b0; s_ack_err = 1'b0; s_rd = 8'h00; mdl_idle = 1'b1;
    att_cnt = 0; nack_n = 0;
    forever begin
      @(posedge clk); #1;
      if (m_ena_s && reset) begin
        mdl_idle = 1'b0; first = 1'b1; more = 1'b1; rp = 0;
        nack_now = (att_cnt < nack_n);
        att_cnt++;
        s_ack_err = 1'b0;
        while (more) begin
          if (first || (m_rw_s != prev_rw)) buslog.push_back(32'h100 | int'({m_addr_s, m_rw_s}));
          prev_rw = m_rw_s;
          cur_rw = m_rw_s;
          if (cur_rw) buslog.push_back(32'h200);
          else buslog.push_back(int'(m_data_wr_s));
          mb = 1'b1;
          repeat (BYTE_T) @(posedge clk);
          #1;
          if (first && nack_now) s_ack_err = 1'b1;
          if (cur_rw) begin
            s_rd = 8'hA0 + 8'(rp);
            rp++;
          end
          first = 1'b0;
          mb = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          more = m_ena_s && reset;
        end
        buslog.push_back(32'h300);
        mdl_idle = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      if (mdl_idle) break;
      @(posedge clk);
    end
    #1;
    chk("model_idle", 64'(mdl_idle), 64'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    ts = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    sel = v.a2; is_read = v.rd; chip_addr = v.chip; reg_addr = v.regad;
    len = v.len; wr_data = v.wr; nack_n = v.nack; att_cnt = 0;
    done_cnt = 0; sd.delete(); si.delete(); buslog.delete();
    pulse_start();
    chk($sformatf("v%0d start_latency", vi), 64'({busy_s, m_ena_s}), 64'b11);
    for (int c = 0; c < 20000; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
    end
    repeat (20) @(posedge clk);
    wait_idle();
    chk($sformatf("v%0d done_count", vi), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d error", vi), 64'(error_s), 64'(v.exp_err));
    chk($sformatf("v%0d busy_low", vi), 64'(busy_s), 64'd0);
    chk($sformatf("v%0d attempts", vi), 64'(att_cnt), 64'(v.exp_att));
    chk($sformatf("v%0d rd_strobes", vi), 64'(sd.size()), 64'(v.exp_rd));
    for (int i = 0; i < sd.size(); i++) begin
      chk($sformatf("v%0d rd_data[%0d]", vi, i), 64'(sd[i]), 64'(8'hA0 + 8'(i % v.exp_n)));
      chk($sformatf("v%0d rd_idx[%0d]", vi, i), 64'(si[i]), 64'(i % v.exp_n));
    end
    expq.delete();
    for (int a = 0; a < v.exp_att; a++) begin
      expq.push_back(32'h100 | int'({v.chip, 1'b0}));
      if (v.a2) expq.push_back(int'(v.regad[15:8]));
      expq.push_back(int'(v.regad[7:0]));
      if (v.rd) begin
        expq.push_back(32'h100 | int'({v.chip, 1'b1}));
        for (int i = 0; i < v.exp_n; i++) expq.push_back(32'h200);
      end else begin
        for (int i = 0; i < v.exp_n; i++) expq.push_back(int'(v.wr[8*i +: 8]));
      end
      expq.push_back(32'h300);
    end
    chk($sformatf("v%0d bus_len", vi), 64'(buslog.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < buslog.size(); i++)
      chk($sformatf("v%0d bus[%0d]", vi, i), 64'(buslog[i]), 64'(expq[i]));
  endtask

  initial begin
    //        a2  rd  chip   reg        len   wr_data                 nack n  att err rd
    vt[0] = '{1'b0, 1'b0, 7'h39, 16'h0041, 4'd1,  64'h10,                 0, 1, 1, 2'd0, 0};
    vt[1] = '{1'b1, 1'b1, 7'h39, 16'h1234, 4'd4,  64'h0,                  0, 4, 1, 2'd0, 4};
    vt[2] = '{1'b0, 1'b0, 7'h39, 16'h0041, 4'd2,  64'h2211,               1, 2, 2, 2'd0, 0};
    vt[3] = '{1'b0, 1'b0, 7'h2C, 16'h0005, 4'd1,  64'h77,                 3, 1, 3, 2'd1, 0};
    vt[4] = '{1'b0, 1'b0, 7'h39, 16'h0008, 4'd0,  64'hC35A,               0, 1, 1, 2'd0, 0};
    vt[5] = '{1'b0, 1'b0, 7'h39, 16'h0009, 4'd11, 64'h8877665544332211,   0, 8, 1, 2'd0, 0};
    vt[6] = '{1'b1, 1'b1, 7'h50, 16'h00FF, 4'd2,  64'h0,                  1, 2, 2, 2'd0, 4};
    vt[7] = '{1'b1, 1'b0, 7'h50, 16'hBEEF, 4'd3,  64'h030201,             0, 3, 1, 2'd0, 0};
    vt[8] = '{1'b0, 1'b1, 7'h39, 16'h0010, 4'd12, 64'h0,                  0, 8, 1, 2'd0, 8};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1;
    chk("reset_outs_a1", 64'(outs_s), 64'd0);
    sel = 1'b1; #1;
    chk("reset_outs_a2", 64'(outs_s), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset asserted mid read burst: outputs clear next cycle, no done
    sel = 1'b1; is_read = 1'b1; chip_addr = 7'h39; reg_addr = 16'h0010;
    len = 4'd8; nack_n = 0; att_cnt = 0; done_cnt = 0; sd.delete(); si.delete();
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      if (sd.size() >= 2) break;
      @(posedge clk);
    end
    chk("midrst_strobes_seen", 64'(sd.size() >= 2), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outs", 64'(outs_s), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    wait_idle();

    // Table-driven transfers
    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Watchdog: m_busy stuck high
    sel = 1'b0; is_read = 1'b0; chip_addr = 7'h39; reg_addr = 16'h0041;
    len = 4'd1; wr_data = 64'h10; nack_n = 0; att_cnt = 0; done_cnt = 0;
    hold = 1'b1;
    repeat (3) @(posedge clk);
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
    end
    #1;
    chk("to_done_count", 64'(done_cnt), 64'd1);
    chk("to_latency", 64'(done_cyc - ts), 64'd1002);
    chk("to_error", 64'(done_err), 64'd2);
    chk("to_m_ena", 64'(done_ena), 64'd0);
    hold = 1'b0;
    wait_idle();
    chk("to_error_hold", 64'(error_s), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_burst_xfer.md
# i2c_burst_xfer

Multi-byte I2C register transfer sequencer. It succeeds the single-register I2C access block: it drives the byte-level `i2c_master` (ena/busy command interface) through configurable 1- or 2-byte register addressing and bursts of 1..MAX_BURST data bytes. It retries automatically on NACK and aborts on a watchdog timeout. It sits between the configuration FSMs (HDMI transmitter, clock generator setup) and the shared `i2c_master`; the master's signals are exposed as ports.

## Interface
- `REG_ADDR_BYTES`, default 1: register address length, 1 or 2 bytes, MSB first.
- `MAX_BURST`, default 8: maximum data bytes per transfer, 1..16.
- `RETRIES`, default 2: extra attempts after a NACK.
- `TIMEOUT_CYCLES`, default 2_000_000: watchdog per attempt, counted in clk cycles.
- `LEN_W`, default $clog2(MAX_BURST+1): width of the `len` port.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: start a transfer. Sampled only in IDLE.
- `chip_addr`, in, 7: 7-bit device address.
- `reg_addr`, in, 16: register address. Only the low 8 bits are used when REG_ADDR_BYTES=1.
- `is_read`, in, 1: 1 = read burst, 0 = write burst.
- `len`, in, LEN_W: byte count, 1..MAX_BURST. A value of 0 is treated as 1; a value above MAX_BURST is clamped to MAX_BURST.
- `wr_data`, in, 8*MAX_BURST: write bytes. Byte i is `wr_data[8i+7:8i]`. The whole bus is captured at start.
- `rd_data`, out, 8: read byte.
- `rd_valid`, out, 1: one-cycle strobe per read byte.
- `rd_idx`, out, LEN_W: index of the current read byte.
- `busy`, out, 1: high from the accepted start until done.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 2: final status. 0 = ok, 1 = NACK after all retries, 2 = timeout. Holds until the next start.
- `m_ena`, `m_addr`[7], `m_rw`, `m_data_wr`[8], out: command outputs to i2c_master.
- `m_busy`, `m_data_rd`[8], `m_ack_error`, in: status inputs from i2c_master.

## Operation
- **Master protocol.**
  - The master accepts a command on the `m_busy` rising edge.
  - The next command must be presented before `m_busy` falls.
  - Changing `m_rw` while `m_ena` is high produces a repeated start.
  - `m_ena` low at byte end produces a stop.
- **Edge detection.** Rising and falling edges of `m_busy` are detected against the registered `m_busy_q`.
- **States:**
  - **IDLE.** On `start`: capture all inputs, set `busy`=1, clear `error`, set the attempt counter to 0, go to CMD.
  - **CMD.** Builds the command list: A address bytes (A = REG_ADDR_BYTES) with rw=0, then N data bytes. For writes the data bytes use rw=0; for reads they use rw=1.
    - On entry: `m_ena`=1, `m_addr`=chip_addr, `m_rw`=0, `m_data_wr`=first address byte. Clear the accepted-command count `k`.
    - On each `m_busy` rising edge: increment `k` and load command `k`.
    - When `k` reaches A+N, drive `m_ena`=0 and go to DRAIN.
  - **DRAIN.** Wait for the `m_busy` falling edge with `m_ena`=0, then go to CHECK.
  - **CHECK.** Evaluate the attempt:
    - `m_ack_error`=1 and attempt < RETRIES: increment attempt, wait 16 idle cycles, go to CMD. The full command list is reissued.
    - `m_ack_error`=1 and attempt = RETRIES: `error`=1, go to FIN.
    - Otherwise: `error`=0, go to FIN.
  - **FIN.** Pulse `done`, set `busy`=0, go to IDLE.
- **Read capture.**
  - On each `m_busy` falling edge whose in-flight command was rw=1: `rd_data`=`m_data_rd`, `rd_valid`=1, `rd_idx`=read index, then increment the read index.
  - The read index is cleared at every attempt start. A retry therefore re-delivers bytes from index 0.
- **Watchdog.** Cleared on entry to CMD. If it reaches TIMEOUT_CYCLES in CMD or DRAIN: `m_ena`=0, `error`=2, go to FIN.
- **Busy-edge corner cases.**
  - `start` while `busy` is high is ignored.
  - A `m_busy` rising edge in IDLE is ignored.

## Timing
- **Reset values:** `m_ena`=0, `m_addr`=0, `m_rw`=0, `m_data_wr`=0, `rd_data`=0, `rd_valid`=0, `rd_idx`=0, `busy`=0, `done`=0, `error`=0, `m_busy_q`=0, state=IDLE.
- **Reset mid-transfer.** Reset forces IDLE in the next cycle. `m_ena`=0 and no `done` pulse is issued. The master finishes its current byte and then stops.
- **Start latency.** `start` sampled at cycle t gives `busy`=1 and `m_ena`=1 at t+1.
- **Command update.** The next command is registered one cycle after the `m_busy` rising edge. This is well inside the master's byte time.
- **Read data.** `rd_valid` fires one cycle after the `m_busy` falling edge.
- **Completion.** `done` fires 2 cycles after the final `m_busy` falling edge (CHECK, then FIN).
- **Simultaneous events.** When a falling edge completes the last read byte and that byte's NACK is detected, the read strobe is still emitted before CHECK.

## Test plan
- **Single write.** REG_ADDR_BYTES=1, chip 0x39, reg 0x41, len 1, wr_data 0x10 -> bus shows S 0x72 ack 0x41 ack 0x10 ack P; one `done` pulse, `error`=0.
- **Two-byte-address read burst.** REG_ADDR_BYTES=2, reg 0x1234, len 4, slave returns A0..A3 -> bus shows the address bytes 0x12 then 0x34, a repeated start with 0x73, then 4 read bytes. Expect 4 `rd_valid` strobes with `rd_idx` 0..3 carrying A0..A3, then `done`.
- **Recovered NACK.** Slave NACKs the first attempt, ACKs the second, RETRIES=2 -> two full command sequences on the bus; `done` with `error`=0.
- **Persistent NACK.** Slave NACKs every attempt, RETRIES=2 -> exactly 3 attempts; `error`=1.
- **Timeout.** `m_busy` held high, TIMEOUT_CYCLES=1000 -> `m_ena`=0 and `done` pulse with `error`=2 at cycle 1000+2 after the attempt start.
- **Reset and clamping.** Reset asserted mid-burst -> all outputs take their reset values next cycle and no `done` pulse occurs. Then len=0 -> one data byte is transferred; len=MAX_BURST+3 -> MAX_BURST data bytes are transferred.
